// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits of two WIDTH-bit operands per clock,
// with a registered carry and a start/busy/done handshake.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, work, work_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   digit_res;
  logic [DIGIT-1:0] digit_sum;
  logic             digit_cout, msb_cin, last;

  // Operands shift right so the active digit is always at the bottom; results
  // enter at the top, leaving digit 0 at the LSB after K shifts.
  always_comb begin
    digit_res  = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + (DIGIT+1)'(carry);
    digit_sum  = digit_res[DIGIT-1:0];
    digit_cout = digit_res[DIGIT];
    // Carry into a digit's top bit is recovered from that bit's sum and inputs.
    msb_cin    = digit_sum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
    work_next  = (work >> DIGIT) | (WIDTH'(digit_sum) << (WIDTH - DIGIT));
    last       = (cnt == CW'(K - 1));
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          a_reg <= a;
          b_reg <= b ^ {WIDTH{sub}};
          carry <= cin ^ sub;
          cnt   <= '0;
          work  <= '0;
        end
        RUN: begin
          a_reg <= a_reg >> DIGIT;
          b_reg <= b_reg >> DIGIT;
          work  <= work_next;
          carry <= digit_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= work_next;
            cout <= digit_cout;
            ovf  <= digit_cout ^ msb_cin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: three configurations (8/1, 16/4, 2/1)
// checked against an arithmetic reference model.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 0, sub8 = 0, cin8 = 0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic        start16 = 0, sub16 = 0, cin16 = 0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  logic       start2 = 0, sub2 = 0, cin2 = 0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16));

  serial_addsub #(.WIDTH(2), .DIGIT(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Selected instance: 0 = 8/1, 1 = 16/4, 2 = 2/1.
  int          sel = 0;
  logic        obs_busy, obs_done, obs_cout, obs_ovf;
  logic [15:0] obs_sum;

  always_comb begin
    obs_busy = busy8; obs_done = done8; obs_cout = cout8; obs_ovf = ovf8;
    obs_sum  = {8'h00, sum8};
    if (sel == 1) begin
      obs_busy = busy16; obs_done = done16; obs_cout = cout16; obs_ovf = ovf16;
      obs_sum  = sum16;
    end else if (sel == 2) begin
      obs_busy = busy2; obs_done = done2; obs_cout = cout2; obs_ovf = ovf2;
      obs_sum  = {14'h0, sum2};
    end
  end

  function automatic int width_of(input int s);
    return (s == 1) ? 16 : (s == 2) ? 2 : 8;
  endfunction

  function automatic int k_of(input int s);
    return (s == 1) ? 4 : (s == 2) ? 2 : 8;
  endfunction

  // Reference: {cout,sum} = a + b + cin or a + ~b + ~cin; ovf when both addends
  // share a sign that the result does not.
  task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       output logic [15:0] s, output logic co, output logic ov);
    logic [16:0] mask, bb, tot;
    mask = (17'd1 << w) - 17'd1;
    bb   = sub ? (~{1'b0, b} & mask) : {1'b0, b};
    tot  = {1'b0, a} + bb + 17'(cin ^ sub);
    s    = 16'(tot & mask);
    co   = tot[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
  endtask

  task automatic drive(input int s, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic sub);
    case (s)
      1: begin start16 = st; a16 = a;       b16 = b;       cin16 = cin; sub16 = sub; end
      2: begin start2  = st; a2  = a[1:0];  b2  = b[1:0];  cin2  = cin; sub2  = sub; end
      default: begin start8 = st; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin; sub8 = sub; end
    endcase
  endtask

  // One operation; negedge n observes the state after edge n (edge 0 samples start).
  // If poke >= 0, a zero-operand start is pulsed while the unit is busy.
  task automatic run_op(input int s, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input int poke);
    int k, busy_n, done_n, done_at;
    logic [15:0] es, gs;
    logic ec, eo, gc, go;
    sel = s;
    k = k_of(s);
    model(width_of(s), a, b, cin, sub, es, ec, eo);
    busy_n = 0; done_n = 0; done_at = -1;
    gs = '0; gc = 0; go = 0;
    @(negedge clk);
    drive(s, 1'b1, a, b, cin, sub);
    for (int n = 0; n < k + 6; n++) begin
      @(negedge clk);
      if (obs_busy) busy_n++;
      if (obs_done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = n; gs = obs_sum; gc = obs_cout; go = obs_ovf;
        end
      end
      if (n == 0) drive(s, 1'b0, ~a, ~b, ~cin, ~sub);
      if (n == poke) drive(s, 1'b1, '0, '0, 1'b0, 1'b0);
      if (n == poke + 1) drive(s, 1'b0, '0, '0, 1'b0, 1'b0);
    end
    check("busy_cycles", busy_n, k);
    check("done_latency", done_at, k);
    check("done_count", done_n, 1);
    check("sum", gs, es);
    check("cout", gc, ec);
    check("ovf", go, eo);
    check("sum_hold", obs_sum, es);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", obs_busy, 0);
    check("rst_done", obs_done, 0);
    check("rst_sum", obs_sum, 0);
    check("rst_cout_ovf", {obs_cout, obs_ovf}, 0);

    run_op(0, 16'h5A, 16'h33, 1'b0, 1'b0, -1);
    run_op(0, 16'h10, 16'h20, 1'b0, 1'b1, -1);
    run_op(0, 16'h80, 16'h01, 1'b0, 1'b1, -1);
    run_op(0, 16'hFF, 16'h01, 1'b1, 1'b0, 3);

    // Abort mid-run: reset during the 4th RUN cycle must clear everything.
    sel = 0;
    run_op(0, 16'h80, 16'h01, 1'b0, 1'b1, -1);
    @(negedge clk);
    drive(0, 1'b1, 16'h37, 16'h44, 1'b0, 1'b0);
    begin
      int done_n;
      done_n = 0;
      for (int n = 0; n < 16; n++) begin
        @(negedge clk);
        if (obs_done) done_n++;
        if (n == 0) drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
        if (n == 3) rst = 1'b1;
        if (n == 4) begin
          check("abort_busy", obs_busy, 0);
          check("abort_done", obs_done, 0);
          check("abort_sum", obs_sum, 0);
          check("abort_cout_ovf", {obs_cout, obs_ovf}, 0);
          rst = 1'b0;
        end
      end
      check("abort_no_done", done_n, 0);
    end
    run_op(0, 16'h01, 16'h02, 1'b0, 1'b0, -1);

    run_op(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, -1);

    for (int i = 0; i < 20; i++)
      run_op(0, 16'($urandom_range(255)), 16'($urandom_range(255)),
             1'($urandom_range(1)), 1'($urandom_range(1)), -1);
    for (int i = 0; i < 8; i++)
      run_op(1, 16'($urandom), 16'($urandom),
             1'($urandom_range(1)), 1'($urandom_range(1)), -1);

    // Exhaustive 2-bit sweep with start held high: one result every K+2 = 4 cycles.
    sel = 2;
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      logic [15:0] ea, eb, es;
      logic ecin, esub, ec, eo;
      int waited;
      ea   = 16'(i & 3);
      eb   = 16'((i >> 2) & 3);
      ecin = 1'((i >> 4) & 1);
      esub = 1'((i >> 5) & 1);
      model(2, ea, eb, ecin, esub, es, ec, eo);
      drive(2, 1'b1, ea, eb, ecin, esub);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!obs_done && waited < 12);
      check("sweep_spacing", waited, (i == 0) ? 3 : 4);
      check("sweep_result", {obs_cout, obs_ovf, obs_sum[1:0]}, {ec, eo, es[1:0]});
    end
    drive(2, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
